prim_bist_ctrl: RTL and testbench
=================================

Name: prim_bist_ctrl

Overview:
Sequential stimulus/response stage that sits directly upstream and downstream of the combinational gate-primitive bank. It drives pseudo-random vectors from an LFSR into the bank and compacts the bank's outputs into a MISR signature. LFSR and MISR feedback are built from `xor` gate primitive instances, so the block also exercises primitive elaboration inside sequential logic.

Parameters:
- W, 8, stimulus/response/signature width; supported range 4..32; taps below are defined for 8.
- CNT_W, 8, width of the vector counter and of num_vec_i.
- TAPS, 8'b1011_1000, feedback tap mask (bits 7,5,4,3, i.e. x^8+x^6+x^5+x^4+1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start_i  in  1  start pulse; honoured only in IDLE or DONE
- seed_i  in  W  LFSR seed, sampled on accepted start
- num_vec_i  in  CNT_W  number of vectors, sampled on accepted start
- stim_o  out  W  stimulus to the primitive bank
- stim_valid_o  out  1  high on every cycle a vector is applied
- resp_i  in  W  combinational response of the bank to stim_o, same cycle
- busy_o  out  1  high in RUN
- done_o  out  1  high in DONE, held until the next accepted start
- signature_o  out  W  MISR contents

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high. Reset forces state IDLE and lfsr, misr, cnt, num_q to 0. All outputs are 0 during and after reset.
- FSM states are IDLE, RUN, DONE.
- IDLE/DONE with start_i=1:
  - num_vec_i==0 → DONE directly; misr<=0.
  - otherwise → RUN; lfsr <= (seed_i==0 ? 1 : seed_i) for lock-up avoidance; misr<=0; cnt<=0; num_q<=num_vec_i.
- RUN:
  - stim_o = lfsr; stim_valid_o = 1.
  - Each cycle: lfsr <= step(lfsr); misr <= step(misr) ^ resp_i; cnt <= cnt+1.
  - When cnt == num_q-1 the transition is to DONE (that cycle's resp_i is still absorbed).
- step(x) = {x[W-2:0], ^(x & TAPS)}. The Fibonacci shift-left is computed by the sub-module.
- stim_o = 0 and stim_valid_o = 0 outside RUN.
- signature_o = misr in every state.
- start_i during RUN is ignored, with no restart and no error.
- Latency: an accepted start at edge k gives stim_valid_o high for cycles k+1 .. k+N. done_o rises at cycle k+N+1.
- num_vec_i = 2^CNT_W-1 is the maximum run. cnt never wraps, because the terminal compare precedes the increment.
- Reset asserted mid-RUN aborts immediately to IDLE; the signature is cleared.

Optional Feature:
- Macro: PRIM_BIST_GOLDEN_CMP_EN
- Defined:
  - Adds input golden_i [W], sampled on accepted start.
  - Adds output pass_o, reset 0.
  - On entry to DONE, pass_o <= (step-final misr == golden_q). pass_o is held through DONE and cleared on the next accepted start.
- Undefined: golden_i and pass_o do not exist; all other behaviour is identical.

Decomposition:
- Package prim_bist_pkg holds:
  - state_e enum {IDLE, RUN, DONE}
  - localparam DEFAULT_TAPS
  - localparam LOCKUP_SEED = 1
- Sub-module prim_bist_step (parameter W, TAPS): purely combinational.
  - Inputs x and inject; output y = step(x) ^ inject.
  - Feedback is a reduction built from a chain of 2-input `xor` primitive instances inside a generate loop.
  - Instantiated twice: the LFSR with inject = 0, and the MISR with inject = resp_i.

Test Plan:
- Basic run: reset, then seed_i=0x01, num_vec_i=4, start pulse, resp_i tied 0 → stim_o = 01,02,04,08 on 4 consecutive cycles; done_o high the following cycle; signature_o = 0x00.
- Tap feedback: seed 0x08, num_vec_i=2 → stim_o = 08, 11.
- Zero seed and loopback: seed_i=0x00, num_vec_i=4, resp_i = ~stim_o (a `not` primitive loopback) → stim_o = 01,02,04,08; signature_o = 0x05.
- Zero count and ignored start: num_vec_i=0 → DONE on the next cycle with no stim_valid_o and signature 0. Separately, start_i pulsed mid-RUN → sequence and count unaffected.
- Reset mid-run: rst asserted asynchronously (mid-cycle) during vector 2 → all outputs 0 immediately, state IDLE; a fresh start then reproduces the sequence from the basic-run case.
- Golden compare (with PRIM_BIST_GOLDEN_CMP_EN): run the zero-seed loopback case with golden_i=0x05 → pass_o=1; rerun with golden_i=0x06 → pass_o=0.

Source files
------------

// File: rtl/prim_bist_pkg.sv
// Shared types and constants for the LFSR/MISR BIST controller.
// Optional golden compare: define PRIM_BIST_GOLDEN_CMP_EN.
package prim_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // x^8+x^6+x^5+x^4+1, taps at bits 7,5,4,3
  localparam logic [7:0] DEFAULT_TAPS = 8'b1011_1000;

  // replaces an all-zero seed, which would lock the LFSR
  localparam int LOCKUP_SEED = 1;

endpackage

// File: rtl/prim_bist_step.sv
// One Fibonacci shift-left step with optional response injection.
// Feedback parity is a chain of 2-input xor primitives.
module prim_bist_step
  import prim_bist_pkg::*;
#(
  parameter int W = 8,
  parameter logic [W-1:0] TAPS = W'(DEFAULT_TAPS)
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] inject,
  output logic [W-1:0] y
);

  logic [W-1:0] masked;
  wire  [W-1:0] chain;

  assign masked = x & TAPS;
  assign chain[0] = masked[0];

  // running parity of the tapped bits, bit by bit
  for (genvar i = 1; i < W; i++) begin : g_par
    xor u_xor (chain[i], chain[i-1], masked[i]);
  end

  assign y = {x[W-2:0], chain[W-1]} ^ inject;

endmodule

// File: rtl/prim_bist_ctrl.sv
// BIST controller: LFSR stimulus into the bank, MISR compaction of
// its response. Optional golden compare: PRIM_BIST_GOLDEN_CMP_EN.
module prim_bist_ctrl
  import prim_bist_pkg::*;
#(
  parameter int W = 8,
  parameter int CNT_W = 8,
  parameter logic [W-1:0] TAPS = W'(DEFAULT_TAPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [W-1:0]     seed_i,
  input  logic [CNT_W-1:0] num_vec_i,
`ifdef PRIM_BIST_GOLDEN_CMP_EN
  input  logic [W-1:0]     golden_i,
  output logic             pass_o,
`endif
  output logic [W-1:0]     stim_o,
  output logic             stim_valid_o,
  input  logic [W-1:0]     resp_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [W-1:0]     signature_o
);

  state_e           state;
  logic [W-1:0]     lfsr;
  logic [W-1:0]     misr;
  logic [W-1:0]     lfsr_nxt;
  logic [W-1:0]     misr_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] num_q;
  logic             last;

`ifdef PRIM_BIST_GOLDEN_CMP_EN
  logic [W-1:0]     golden_q;
  logic             pass_q;
  assign pass_o = pass_q;
`endif

  prim_bist_step #(
    .W    (W),
    .TAPS (TAPS)
  ) u_lfsr_step (
    .x      (lfsr),
    .inject ('0),
    .y      (lfsr_nxt)
  );

  prim_bist_step #(
    .W    (W),
    .TAPS (TAPS)
  ) u_misr_step (
    .x      (misr),
    .inject (resp_i),
    .y      (misr_nxt)
  );

  // compare before increment so cnt never wraps
  assign last = (cnt == num_q - CNT_W'(1));

  // sequencer: load on start, shift while running, hold when done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lfsr  <= '0;
      misr  <= '0;
      cnt   <= '0;
      num_q <= '0;
`ifdef PRIM_BIST_GOLDEN_CMP_EN
      golden_q <= '0;
      pass_q   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start_i) begin
            misr <= '0;
`ifdef PRIM_BIST_GOLDEN_CMP_EN
            golden_q <= golden_i;
            pass_q   <= 1'b0;
`endif
            if (num_vec_i == '0) begin
              state <= DONE;
`ifdef PRIM_BIST_GOLDEN_CMP_EN
              // empty run: final signature is zero
              pass_q <= (golden_i == '0);
`endif
            end else begin
              state <= RUN;
              lfsr  <= (seed_i == '0) ? W'(LOCKUP_SEED)
                                      : seed_i;
              cnt   <= '0;
              num_q <= num_vec_i;
            end
          end
        end
        RUN: begin
          lfsr <= lfsr_nxt;
          misr <= misr_nxt;
          cnt  <= cnt + CNT_W'(1);
          if (last) begin
            state <= DONE;
`ifdef PRIM_BIST_GOLDEN_CMP_EN
            pass_q <= (misr_nxt == golden_q);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o       = (state == RUN);
  assign done_o       = (state == DONE);
  assign stim_valid_o = busy_o;
  assign stim_o       = busy_o ? lfsr : '0;
  assign signature_o  = misr;

endmodule

// File: tb/tb_prim_bist_ctrl.sv
// Randomized bench for prim_bist_ctrl against an arithmetic model.
// Build with PRIM_BIST_GOLDEN_CMP_EN to also check pass_o.
module tb_prim_bist_ctrl;

  localparam logic [7:0] TAPS = 8'hB8;
  localparam int M_RAND = 0;
  localparam int M_LOOP = 1;
  localparam int M_ZERO = 2;

  logic       clk;
  logic       rst;
  logic       start_i;
  logic [7:0] seed_i;
  logic [7:0] num_vec_i;
  logic [7:0] stim_o;
  logic       stim_valid_o;
  logic [7:0] resp_i;
  logic       busy_o;
  logic       done_o;
  logic [7:0] signature_o;
`ifdef PRIM_BIST_GOLDEN_CMP_EN
  logic [7:0] golden_i;
  logic       pass_o;
`endif

  int errors = 0;
  int checks = 0;

  prim_bist_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .seed_i       (seed_i),
    .num_vec_i    (num_vec_i),
`ifdef PRIM_BIST_GOLDEN_CMP_EN
    .golden_i     (golden_i),
    .pass_o       (pass_o),
`endif
    .stim_o       (stim_o),
    .stim_valid_o (stim_valid_o),
    .resp_i       (resp_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .signature_o  (signature_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // shift left by one, new lsb = parity of tapped bits
  function automatic logic [7:0] mstep(logic [7:0] x);
    int v;
    v = (int'(x) * 2) % 256 + ($countones(x & TAPS) % 2);
    return 8'(v);
  endfunction

  // one complete run; poke = vector index at which start is
  // pulsed again (must be ignored), -1 for none
  task automatic run(logic [7:0] seed, logic [7:0] n, int mode,
                     int poke, logic [7:0] gold);
    logic [7:0] l;
    logic [7:0] sig;
    logic [7:0] r;
    @(negedge clk);
    start_i   = 1'b1;
    seed_i    = seed;
    num_vec_i = n;
`ifdef PRIM_BIST_GOLDEN_CMP_EN
    golden_i  = gold;
`endif
    @(posedge clk);
    #1;
    start_i   = 1'b0;
    seed_i    = 8'($urandom);
    num_vec_i = 8'($urandom);
`ifdef PRIM_BIST_GOLDEN_CMP_EN
    golden_i  = 8'($urandom);
`endif
    l   = (seed == 8'd0) ? 8'd1 : seed;
    sig = 8'd0;
    for (int i = 0; i < int'(n); i++) begin
      if (mode == M_LOOP) r = ~l;
      else if (mode == M_ZERO) r = 8'd0;
      else r = 8'($urandom);
      resp_i = r;
      @(negedge clk);
      check("stim", 32'(stim_o), 32'(l));
      check("run_flags", {29'd0, stim_valid_o, busy_o, done_o},
            32'b110);
      if (i == poke) start_i = 1'b1;
      sig = mstep(sig) ^ r;
      l   = mstep(l);
      @(posedge clk);
      #1;
      start_i = 1'b0;
    end
    resp_i = 8'($urandom);
    #1;
    check("done_flags", {29'd0, stim_valid_o, busy_o, done_o},
          32'b001);
    check("stim_idle", 32'(stim_o), 32'd0);
    check("signature", 32'(signature_o), 32'(sig));
`ifdef PRIM_BIST_GOLDEN_CMP_EN
    check("pass", 32'(pass_o), 32'(sig == gold));
`else
    if (gold == 8'hFF) sig = 8'd0;
`endif
  endtask

  task automatic check_zero(string tag);
    check(tag, {13'd0, stim_o, stim_valid_o, busy_o, done_o,
                signature_o}, 32'd0);
`ifdef PRIM_BIST_GOLDEN_CMP_EN
    check({tag, "_pass"}, 32'(pass_o), 32'd0);
`endif
  endtask

  initial begin
    rst       = 1'b1;
    start_i   = 1'b0;
    seed_i    = 8'd0;
    num_vec_i = 8'd0;
    resp_i    = 8'd0;
`ifdef PRIM_BIST_GOLDEN_CMP_EN
    golden_i  = 8'd0;
`endif
    #12;
    check_zero("in_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("after_reset");

    run(8'h01, 8'd4, M_ZERO, -1, 8'h00);
    run(8'h08, 8'd2, M_ZERO, -1, 8'h00);
    run(8'h00, 8'd4, M_LOOP, -1, 8'h05);
    run(8'h00, 8'd4, M_LOOP, -1, 8'h06);
    run(8'h3C, 8'd0, M_RAND, -1, 8'h00);
    run(8'h5A, 8'd10, M_RAND, 3, 8'h11);
    run(8'hC3, 8'd5, M_RAND, 4, 8'h22);

    // asynchronous reset in the middle of vector 2
    @(negedge clk);
    start_i   = 1'b1;
    seed_i    = 8'h01;
    num_vec_i = 8'd4;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    resp_i  = 8'hA5;
    @(posedge clk);
    #3;
    check("pre_abort_busy", 32'(busy_o), 32'd1);
    rst = 1'b1;
    #1;
    check_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("abort_idle");
    run(8'h01, 8'd4, M_ZERO, -1, 8'h00);

    for (int k = 0; k < 25; k++) begin
      logic [7:0] s;
      logic [7:0] n;
      s = (k % 5 == 0) ? 8'd0 : 8'($urandom);
      n = 8'($urandom_range(0, 20));
      run(s, n, M_RAND, $urandom_range(0, 24) - 2,
          8'($urandom));
    end

    run(8'h77, 8'd255, M_RAND, 100, 8'h00);
    run(8'h00, 8'd4, M_LOOP, -1, 8'h05);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
